// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: aging-priority arbiter that grants the shared FIFO read port for whole bursts
module fifo_rd_arbiter #(
    parameter int N_CH     = 8,
    parameter int PRI_W    = 8,
    parameter int AGE_STEP = 1,
    parameter int TIMEOUT  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH*PRI_W-1:0] pri_bus,
    input  logic                  xfer_vld,
    input  logic                  xfer_rdy,
    input  logic                  xfer_last,
    output logic [N_CH-1:0]       gnt,
    output logic [2:0]            gnt_idx,
    output logic                  gnt_vld,
    output logic                  timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t            state, state_n;
    logic [PRI_W-1:0]  age     [N_CH];
    logic [PRI_W-1:0]  age_n   [N_CH];
    logic [PRI_W-1:0]  age_inc [N_CH];
    logic [PRI_W-1:0]  eff     [N_CH];
    logic [PRI_W:0]    sum     [N_CH];
    logic [PRI_W:0]    inc     [N_CH];
    logic [PRI_W-1:0]  best;
    logic [2:0]        win, gnt_idx_n;
    logic [N_CH-1:0]   gnt_n;
    logic [WD_W-1:0]   wd, wd_n;
    logic              terr_n, beat;

    assign beat    = xfer_vld & xfer_rdy;
    assign gnt_vld = (state == BUSY);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sum[i]     = {1'b0, pri_bus[i*PRI_W +: PRI_W]} + {1'b0, age[i]};
            eff[i]     = sum[i][PRI_W] ? '1 : sum[i][PRI_W-1:0];
            inc[i]     = {1'b0, age[i]} + (PRI_W+1)'(AGE_STEP);
            age_inc[i] = inc[i][PRI_W] ? '1 : inc[i][PRI_W-1:0];
        end
    end

    // scanning downward with >= leaves the lowest index among equal maxima
    always_comb begin
        best = '0;
        win  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i] && eff[i] >= best) begin
                best = eff[i];
                win  = 3'(i);
            end
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_idx_n = gnt_idx;
        terr_n    = 1'b0;
        wd_n      = wd;
        for (int i = 0; i < N_CH; i++) age_n[i] = age[i];
        if (state == IDLE) begin
            if (|req) begin
                state_n   = BUSY;
                gnt_n     = N_CH'(1) << win;
                gnt_idx_n = win;
                wd_n      = '0;
                for (int i = 0; i < N_CH; i++)
                    age_n[i] = (req[i] && win != 3'(i)) ? age_inc[i] : '0;
            end
        end else if ((beat && xfer_last) || (!beat && wd == WD_W'(TIMEOUT - 1))) begin
            state_n   = IDLE;
            gnt_n     = '0;
            gnt_idx_n = '0;
            wd_n      = '0;
            terr_n    = !(beat && xfer_last);
        end else begin
            wd_n = beat ? '0 : wd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            timeout_err <= 1'b0;
            wd          <= '0;
            for (int i = 0; i < N_CH; i++) age[i] <= '0;
        end else begin
            state       <= state_n;
            gnt         <= gnt_n;
            gnt_idx     <= gnt_idx_n;
            timeout_err <= terr_n;
            wd          <= wd_n;
            for (int i = 0; i < N_CH; i++) age[i] <= age_n[i];
        end
    end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed bench with a behavioural arbitration model checked every cycle
module tb_fifo_rd_arbiter;
    localparam int N_CH = 8, PRI_W = 8, AGE_STEP = 1, TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req = '0;
    logic [63:0] pri_bus = '0;
    logic        xfer_vld = 1'b0, xfer_rdy = 1'b0, xfer_last = 1'b0;
    logic [7:0]  gnt;
    logic [2:0]  gnt_idx;
    logic        gnt_vld, timeout_err;

    int n_cmp = 0, n_err = 0;
    bit chk_en = 1'b0;

    int m_age [8];
    bit m_busy = 1'b0;
    bit m_terr = 1'b0;
    int m_ch = 0;
    int m_since = 0;

    always #5 clk = ~clk;

    fifo_rd_arbiter #(.N_CH(N_CH), .PRI_W(PRI_W), .AGE_STEP(AGE_STEP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .pri_bus(pri_bus),
        .xfer_vld(xfer_vld), .xfer_rdy(xfer_rdy), .xfer_last(xfer_last),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_of(int i);
        int e = int'(pri_bus[i*8 +: 8]) + m_age[i];
        return (e > 255) ? 255 : e;
    endfunction

    // highest effective priority among requesters, then the lowest index holding it
    function automatic int pick();
        int mx = -1;
        for (int i = 0; i < N_CH; i++) if (req[i] && eff_of(i) > mx) mx = eff_of(i);
        for (int i = 0; i < N_CH; i++) if (req[i] && eff_of(i) == mx) return i;
        return 0;
    endfunction

    initial begin : model
        int w;
        foreach (m_age[i]) m_age[i] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 1'b0; m_terr = 1'b0; m_since = 0; m_ch = 0;
                foreach (m_age[i]) m_age[i] = 0;
            end else begin
                m_terr = 1'b0;
                if (!m_busy) begin
                    if (req != 0) begin
                        w = pick();
                        for (int i = 0; i < N_CH; i++)
                            m_age[i] = (req[i] && i != w) ? ((m_age[i] + AGE_STEP > 255) ? 255 : m_age[i] + AGE_STEP) : 0;
                        m_ch = w; m_busy = 1'b1; m_since = 0;
                    end
                end else if (xfer_vld && xfer_rdy && xfer_last) begin
                    m_busy = 1'b0;
                end else begin
                    m_since = (xfer_vld && xfer_rdy) ? 0 : m_since + 1;
                    if (m_since == TIMEOUT) begin
                        m_busy = 1'b0; m_terr = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("gnt", 32'(gnt), m_busy ? (32'd1 << m_ch) : 32'd0);
                chk("gnt_vld", 32'(gnt_vld), 32'(m_busy));
                chk("timeout_err", 32'(timeout_err), 32'(m_terr));
                if (m_busy) chk("gnt_idx", 32'(gnt_idx), 32'(m_ch));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pri(input int ch, input int v);
        pri_bus[ch*8 +: 8] = 8'(v);
    endtask

    task automatic beat(input bit last);
        xfer_vld = 1'b1; xfer_rdy = 1'b1; xfer_last = last;
        step();
        xfer_vld = 1'b0; xfer_rdy = 1'b0; xfer_last = 1'b0;
    endtask

    // grant seen one cycle after IDLE sampling, then a single last beat returns to IDLE
    task automatic arb(input logic [7:0] exp, input string nm);
        step();
        chk(nm, 32'(gnt), 32'(exp));
        beat(1'b1);
    endtask

    initial begin
        step(3);
        chk_en = 1'b1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_idx", 32'(gnt_idx), 0);
        chk("rst_vld", 32'(gnt_vld), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        rst = 1'b0;

        set_pri(3, 'h10); req = 8'h08;
        step();
        chk("single_gnt", 32'(gnt), 32'h08);
        chk("single_idx", 32'(gnt_idx), 3);
        req = 8'h00;
        xfer_vld = 1'b1; xfer_rdy = 1'b0; xfer_last = 1'b1;
        step();
        chk("no_rdy_hold", 32'(gnt), 32'h08);
        xfer_vld = 1'b0; xfer_last = 1'b0;
        beat(1'b0); beat(1'b0); beat(1'b0); beat(1'b1);
        chk("burst4_release", 32'(gnt), 0);

        for (int i = 0; i < 8; i++) set_pri(i, 'h40);
        req = 8'hFF;
        arb(8'h01, "all_tie_ch0");
        req = 8'hFE;
        arb(8'h02, "no_ch0_ch1");

        req = 8'hFF;
        step();
        chk("aged_ch2", 32'(gnt), 32'h04);
        beat(1'b0);
        rst = 1'b1;
        step();
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_vld", 32'(gnt_vld), 0);
        chk("midrst_terr", 32'(timeout_err), 0);
        rst = 1'b0;
        arb(8'h01, "post_rst_ages_zero");
        req = 8'h00;
        rst = 1'b1; step(); rst = 1'b0;

        for (int i = 0; i < 8; i++) set_pri(i, 0);
        set_pri(0, 'h80); set_pri(5, 'h7E);
        req = 8'h21;
        arb(8'h01, "age_arb1");
        arb(8'h01, "age_arb2");
        chk("model_age5", 32'(m_age[5]), 2);
        arb(8'h01, "age_arb3_tie");
        arb(8'h20, "age_arb4_ch5");
        chk("model_age5_clr", 32'(m_age[5]), 0);
        arb(8'h01, "age_arb5");
        req = 8'h00;

        set_pri(0, 'hFF); set_pri(1, 'hFF); set_pri(2, 'hF0);
        req = 8'h07;
        arb(8'h01, "sat_arb1");
        req = 8'h06;
        arb(8'h02, "sat_arb2_ch1");
        req = 8'h00;

        set_pri(4, 'h10); req = 8'h10;
        step();
        chk("to_grant", 32'(gnt), 32'h10);
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            req = 8'($urandom);
            pri_bus = {$urandom, $urandom};
            step();
            chk("busy_frozen", 32'(gnt), 32'h10);
        end
        req = 8'h00;
        step();
        chk("to_release", 32'(gnt), 0);
        chk("to_pulse", 32'(timeout_err), 1);
        step();
        chk("to_pulse_end", 32'(timeout_err), 0);

        pri_bus = '0; req = 8'h10;
        step();
        req = 8'h00;
        step(TIMEOUT - 1);
        chk("expiry_hold", 32'(gnt), 32'h10);
        beat(1'b1);
        chk("expiry_last_gnt", 32'(gnt), 0);
        chk("expiry_last_noerr", 32'(timeout_err), 0);

        req = 8'h10;
        step();
        req = 8'h00;
        for (int b = 0; b < 3; b++) begin
            step(99);
            beat(1'b0);
        end
        step(150);
        chk("slow_beats_hold", 32'(gnt), 32'h10);
        beat(1'b1);
        chk("slow_beats_release", 32'(gnt), 0);
        chk("slow_beats_noerr", 32'(timeout_err), 0);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
